// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: a small circular FIFO of (pc, inst) pairs with
// registered occupancy, flush-to-empty, and zeroed outputs when empty.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  // Readiness depends only on registered occupancy, never on id_ready.
  assign if_ready = (count_reg < FULL_CNT);
  assign id_valid = (count_reg != '0);
  assign count    = count_reg;

  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & id_ready & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= if_pc;
      inst_mem[wr_ptr_reg] <= if_inst;
    end
  end

  assign id_pc   = id_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign id_inst = id_valid ? inst_mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized bench for if_id_queue checked every cycle against a queue-based
// reference model, plus directed fill/drain, stream, full, flush, wrap, reset.
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              if_valid = 1'b0;
  logic [ADDR_W-1:0] if_pc = '0;
  logic [INST_W-1:0] if_inst = '0;
  logic              if_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_ready = 1'b0;
  logic [CNT_W-1:0]  count;

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t model_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    logic [63:0] exp_pc, exp_inst;
    n = model_q.size();
    exp_pc   = (n != 0) ? 64'(model_q[0].pc)   : 64'd0;
    exp_inst = (n != 0) ? 64'(model_q[0].inst) : 64'd0;
    check_eq({tag, ".count"},    64'(count),    64'(n));
    check_eq({tag, ".if_ready"}, 64'(if_ready), 64'(n < DEPTH));
    check_eq({tag, ".id_valid"}, 64'(id_valid), 64'(n != 0));
    check_eq({tag, ".id_pc"},    64'(id_pc),    exp_pc);
    check_eq({tag, ".id_inst"},  64'(id_inst),  exp_inst);
  endtask

  // One clock cycle: drive, check model vs DUT at negedge, advance model at posedge.
  task automatic cycle(input logic v, input logic [ADDR_W-1:0] pc, input logic rdy,
                       input logic fl, input string tag);
    logic do_push, do_pop;
    entry_t e;
    if_valid = v;
    if_pc    = pc;
    if_inst  = $urandom;
    id_ready = rdy;
    flush    = fl;
    @(negedge clk);
    check_outputs(tag);
    do_pop  = !fl && (model_q.size() != 0) && rdy;
    do_push = !fl && v && (model_q.size() < DEPTH);
    e.pc   = pc;
    e.inst = if_inst;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      $display("[%0t] %s flush", $time, tag);
    end else begin
      if (do_pop) begin
        $display("[%0t] %s pop  pc=0x%0h", $time, tag, model_q[0].pc);
        model_q.delete(0);
      end
      if (do_push) begin
        model_q.push_back(e);
        $display("[%0t] %s push pc=0x%0h", $time, tag, pc);
      end
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed;
    int guard;
    logic v, accept;

    // Reset held: outputs must be idle with and without clock edges.
    #3;
    check_outputs("reset");
    @(posedge clk); #1;
    check_outputs("reset_edge");
    #2 rst = 1'b1;

    // Fill then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0, "fill");
    check_eq("fill.count", 64'(count), 64'd4);
    check_eq("fill.if_ready", 64'(if_ready), 64'd0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    check_eq("drain.id_valid", 64'(id_valid), 64'd0);
    check_eq("drain.id_pc", 64'(id_pc), 64'd0);

    // Streaming push+pop every cycle from empty.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h400 + 32'(4*i), 1'b1, 1'b0, "stream");
    check_eq("stream.count", 64'(count), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, "stream_end");

    // Full with simultaneous pop: head leaves, offered entry refused.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h500 + 32'(4*i), 1'b0, 1'b0, "refill");
    cycle(1'b1, 32'h600, 1'b1, 1'b0, "full_pop");
    check_eq("full_pop.count", 64'(count), 64'd3);
    check_eq("full_pop.if_ready", 64'(if_ready), 64'd1);
    check_eq("full_pop.id_pc", 64'(id_pc), 64'h504);

    // Flush wins over a concurrent push and pop.
    cycle(1'b1, 32'h700, 1'b1, 1'b1, "flush");
    check_eq("flush.count", 64'(count), 64'd0);
    check_eq("flush.id_valid", 64'(id_valid), 64'd0);
    cycle(1'b1, 32'h200, 1'b0, 1'b0, "post_flush");
    check_eq("post_flush.id_pc", 64'(id_pc), 64'h200);
    cycle(1'b0, '0, 1'b1, 1'b0, "post_flush_drain");

    // Wrap-around: 10 pushes with random pops, then drain.
    pushed = 0;
    guard  = 0;
    while ((pushed < 10 || model_q.size() != 0) && guard < 200) begin
      v = (pushed < 10) && ($urandom_range(0, 3) != 0);
      accept = v && (model_q.size() < DEPTH);
      cycle(v, 32'h800 + 32'(4*pushed), 1'($urandom_range(0, 1)), 1'b0, "wrap");
      if (accept) pushed++;
      guard++;
    end
    check_eq("wrap.pushed", 64'(pushed), 64'd10);
    check_eq("wrap.count", 64'(count), 64'd0);

    // Asynchronous reset mid-cycle with two entries held.
    cycle(1'b1, 32'h900, 1'b0, 1'b0, "pre_rst");
    cycle(1'b1, 32'h904, 1'b0, 1'b0, "pre_rst");
    check_eq("pre_rst.count", 64'(count), 64'd2);
    if_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_eq("async_rst.count", 64'(count), 64'd0);
    check_eq("async_rst.id_valid", 64'(id_valid), 64'd0);
    check_eq("async_rst.id_inst", 64'(id_inst), 64'd0);
    check_eq("async_rst.if_ready", 64'(if_ready), 64'd1);
    model_q.delete();
    #1 rst = 1'b1;

    // Random soak including occasional flushes.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), "soak");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
